// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states,
// default latencies.
package mdu_pkg;

   typedef enum logic [2:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_DIV   = 3'd2,
      OP_DIVU  = 3'd3,
      OP_MTHI  = 3'd4,
      OP_MTLO  = 3'd5
   } mdu_op_e;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } mdu_state_e;

   localparam int MDU_MULT_CYCLES = 5;
   localparam int MDU_DIV_CYCLES  = 10;

   function automatic logic is_div(logic [2:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational HI/LO result generation for MULT/MULTU and, when MDU_DIV_EN is
// defined, DIV/DIVU. Without MDU_DIV_EN no divider is built and DIV/DIVU are not long ops.
module mdu_arith
   import mdu_pkg::*;
(
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] res_hi,
   output logic [31:0] res_lo,
   output logic        long_op,
   output logic        div_zero
);

   logic [63:0] sprod, uprod;

   // Low 64 bits of the sign-extended product are the signed product.
   assign sprod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
   assign uprod = {32'd0, a} * {32'd0, b};

`ifdef MDU_DIV_EN
   logic        sgn;
   logic [31:0] ma, mb, dv, q, r, qs, rs;

   // Divide magnitudes unsigned, then restore signs; keeps 0x80000000 / -1 well defined.
   assign sgn = (op == OP_DIV);
   assign ma  = (sgn && a[31]) ? -a : a;
   assign mb  = (sgn && b[31]) ? -b : b;
   assign dv  = (b == 32'd0) ? 32'd1 : mb;
   assign q   = ma / dv;
   assign r   = ma % dv;
   assign qs  = (sgn && (a[31] ^ b[31])) ? -q : q;
   assign rs  = (sgn && a[31]) ? -r : r;
`endif

   always_comb begin
      res_hi   = uprod[63:32];
      res_lo   = uprod[31:0];
      long_op  = 1'b0;
      div_zero = 1'b0;
      case (op)
         OP_MULT: begin
            res_hi  = sprod[63:32];
            res_lo  = sprod[31:0];
            long_op = 1'b1;
         end
         OP_MULTU: long_op = 1'b1;
`ifdef MDU_DIV_EN
         OP_DIV, OP_DIVU: begin
            res_hi   = rs;
            res_lo   = qs;
            long_op  = 1'b1;
            div_zero = (b == 32'd0);
         end
`endif
         default: ;
      endcase
   end

endmodule

// File: rtl/mdu_ctrl.sv
// MDU controller: IDLE/BUSY FSM with latency counter, HI/LO registers and read mux.
// Divide support is enabled with macro MDU_DIV_EN (see mdu_arith).
module mdu_ctrl
   import mdu_pkg::*;
#(
   parameter int MULT_CYCLES = MDU_MULT_CYCLES,
   parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        md_inst_d,
   input  logic        rd_sel,
   output logic        busy,
   output logic        stall_req,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] rd_data
);

   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

   mdu_state_e  state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [31:0] pend_hi, pend_lo, res_hi, res_lo;
   logic        long_op, div_zero, load, commit, mthi_we, mtlo_we;

   mdu_arith u_arith (
      .op      (op),
      .a       (src_a),
      .b       (src_b),
      .res_hi  (res_hi),
      .res_lo  (res_lo),
      .long_op (long_op),
      .div_zero(div_zero)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= S_IDLE;
         cnt     <= '0;
         pend_hi <= '0;
         pend_lo <= '0;
         hi      <= '0;
         lo      <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         // Divide by zero re-commits the current HI/LO so they appear unchanged.
         if (load) begin
            pend_hi <= div_zero ? hi : res_hi;
            pend_lo <= div_zero ? lo : res_lo;
         end
         if (commit) begin
            hi <= pend_hi;
            lo <= pend_lo;
         end
         if (mthi_we) hi <= src_a;
         if (mtlo_we) lo <= src_a;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      load     = 1'b0;
      commit   = 1'b0;
      case (state)
         S_IDLE:
            if (start && long_op) begin
               state_nx = S_BUSY;
               cnt_nx   = is_div(op) ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);
               load     = 1'b1;
            end
         S_BUSY:
            if (cnt == '0) begin
               state_nx = S_IDLE;
               commit   = 1'b1;
            end else begin
               cnt_nx = cnt - CW'(1);
            end
         default: state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      busy      = (state == S_BUSY);
      stall_req = md_inst_d & (busy | (start & long_op));
      mthi_we   = (state == S_IDLE) && start && (op == OP_MTHI);
      mtlo_we   = (state == S_IDLE) && start && (op == OP_MTLO);
   end

   assign rd_data = rd_sel ? hi : lo;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: driver pushes model-predicted HI/LO and latency,
// monitor pops on each completed operation and also checks stall_req and rd_data every cycle.
module tb_mdu_ctrl;
   import mdu_pkg::*;

   localparam int MULT_C = 5;
   localparam int DIV_C  = 10;
`ifdef MDU_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   typedef struct {
      int          iss;
      int          cyc;
      logic [31:0] hi;
      logic [31:0] lo;
   } exp_t;

   logic        clk = 1'b0, reset = 1'b1, start = 1'b0, md_inst_d = 1'b0, rd_sel = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [31:0] src_a = '0, src_b = '0;
   logic        busy, stall_req;
   logic [31:0] hi, lo, rd_data;

   int          nchk = 0, nfail = 0, cyc_n = 0, run = 0;
   logic [31:0] mhi = '0, mlo = '0, chi = '0, clo = '0;
   exp_t        sb[$];

   mdu_ctrl #(.MULT_CYCLES(MULT_C), .DIV_CYCLES(DIV_C)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
      .md_inst_d(md_inst_d), .rd_sel(rd_sel), .busy(busy), .stall_req(stall_req),
      .hi(hi), .lo(lo), .rd_data(rd_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc_n++;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc_n);
      end
   endtask

   function automatic logic is_long(logic [2:0] o);
      return (o == OP_MULT) || (o == OP_MULTU) || (DIV_EN && ((o == OP_DIV) || (o == OP_DIVU)));
   endfunction

   // Architectural effect of one instruction, computed with 64-bit integer arithmetic.
   function automatic exp_t model(logic [2:0] o, logic [31:0] a, logic [31:0] b);
      exp_t        e;
      longint      sa, sbv, ua, ub;
      logic [63:0] p, q, r;
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      ua  = longint'(a);
      ub  = longint'(b);
      e.iss = 0; e.cyc = 0; e.hi = mhi; e.lo = mlo;
      case (o)
         OP_MULT:  begin p = sa * sbv; e.hi = p[63:32]; e.lo = p[31:0]; e.cyc = MULT_C; end
         OP_MULTU: begin p = ua * ub;  e.hi = p[63:32]; e.lo = p[31:0]; e.cyc = MULT_C; end
         OP_DIV, OP_DIVU:
            if (DIV_EN) begin
               e.cyc = DIV_C;
               if (b != 0) begin
                  if (o == OP_DIV) begin q = sa / sbv; r = sa % sbv; end
                  else             begin q = ua / ub;  r = ua % ub;  end
                  e.lo = q[31:0];
                  e.hi = r[31:0];
               end
            end
         OP_MTHI: e.hi = a;
         OP_MTLO: e.lo = a;
         default: ;
      endcase
      return e;
   endfunction

   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic md);
      exp_t e;
      @(posedge clk); #1;
      e     = model(o, a, b);
      e.iss = cyc_n;
      mhi   = e.hi;
      mlo   = e.lo;
      start = 1'b1; op = o; src_a = a; src_b = b; md_inst_d = md;
      sb.push_back(e);
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
      if (sb.size() != 0) begin
         nchk++; nfail++;
         $display("FAIL timeout: op %0d never completed", o);
         sb.delete();
         run = 0;
      end
   endtask

   // Monitor: retire the oldest expectation when the DUT is idle after its issue edge.
   initial begin : mon
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset) continue;
         chk("stall_req", {31'd0, stall_req}, {31'd0, md_inst_d & (busy | (start & is_long(op)))});
         if (busy) run++;
         else if (sb.size() > 0 && cyc_n > sb[0].iss) begin
            e = sb.pop_front();
            chk("busy_cycles", 32'(run), 32'(e.cyc));
            chk("hi", hi, e.hi);
            chk("lo", lo, e.lo);
            chi = e.hi;
            clo = e.lo;
            run = 0;
         end
         chk("rd_data", rd_data, rd_sel ? chi : clo);
      end
   end

   initial begin : rdsel_drv
      forever begin
         @(posedge clk); #2;
         rd_sel = 1'($urandom_range(0, 1));
      end
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : drv
      repeat (2) @(posedge clk);
      #1 chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_hi", hi, 32'd0);
      chk("reset_lo", lo, 32'd0);
      chk("reset_stall", {31'd0, stall_req}, 32'd0);
      reset = 1'b0;

      issue(OP_MULT,  32'hFFFFFFFE, 32'd3, 1'b1);
      issue(OP_MULTU, 32'hFFFFFFFE, 32'd3, 1'b1);
      issue(OP_DIV,   32'hFFFFFFF9, 32'd2, 1'b1);
      issue(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 1'b0);
      issue(OP_MTHI,  32'h00000011, 32'd0, 1'b0);
      issue(OP_MTLO,  32'h00000022, 32'd0, 1'b1);
      issue(OP_DIVU,  32'd5, 32'd0, 1'b1);

      // A start arriving while busy must be ignored.
      @(posedge clk); #1;
      begin
         exp_t e;
         e = model(OP_MULT, 32'd7, 32'd9); e.iss = cyc_n; mhi = e.hi; mlo = e.lo;
         start = 1'b1; op = OP_MULT; src_a = 32'd7; src_b = 32'd9; md_inst_d = 1'b0;
         sb.push_back(e);
      end
      @(posedge clk); #1; start = 1'b0;
      @(posedge clk); #1; start = 1'b1; op = OP_MTHI; src_a = 32'hBAD0BAD0;
      @(posedge clk); #1; start = 1'b0;
      for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
      chk("busy_ignore_drain", 32'(sb.size()), 32'd0);

      issue(OP_MTLO, 32'hDEADBEEF, 32'd0, 1'b0);

      // Reset in the third busy cycle of a MULT discards it.
      @(posedge clk); #1;
      start = 1'b1; op = OP_MULT; src_a = 32'd5; src_b = 32'd7; md_inst_d = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      #1 chk("midreset_busy", {31'd0, busy}, 32'd0);
      chk("midreset_hi", hi, 32'd0);
      chk("midreset_lo", lo, 32'd0);
      chk("midreset_stall", {31'd0, stall_req}, 32'd0);
      sb.delete(); run = 0; chi = '0; clo = '0; mhi = '0; mlo = '0;
      @(posedge clk); #1 reset = 1'b0;
      issue(OP_MULT, 32'd2, 32'd3, 1'b1);

      for (int n = 0; n < 40; n++) begin
         logic [2:0]  o;
         logic [31:0] a, b;
         o = 3'($urandom_range(0, 5));
         a = $urandom;
         b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 9)) - 32'd4;
         issue(o, a, b, 1'($urandom_range(0, 1)));
      end

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule
